xrv_id_pipe: RTL and testbench

//  Parametrised decode stage between fetch and execute. Decodes an expanded 32-bit RV32 instruction.

---
 rtl/xrv_id_pipe_if.sv | 39 +++
 rtl/xrv_id_pipe.sv | 165 ++++++++++++++++
 tb/tb_xrv_id_pipe.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/xrv_id_pipe_if.sv
// Fetch -> decode -> execute handshake bundle for the RV32 decode stage.
// The master side is fetch/execute (or a bench); the slave side is the decoder.
interface xrv_id_pipe_if;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic        in_compressed;
  logic        out_valid;
  logic        out_ready;
  logic [10:0] out_op;
  logic [31:0] out_imm;
  logic [4:0]  out_src1;
  logic [4:0]  out_src2;
  logic [4:0]  out_dest;
  logic [2:0]  out_funct3;
  logic [6:0]  out_funct7;
  logic [31:0] out_pc;
  logic        out_compressed;
  logic        out_is_mul;
  logic        out_illegal;
  logic        id_jmp;
  logic [31:0] id_jmp_addr;

  modport master (
    output flush, in_valid, in_inst, in_pc, in_compressed, out_ready,
    input  in_ready, out_valid, out_op, out_imm, out_src1, out_src2, out_dest,
           out_funct3, out_funct7, out_pc, out_compressed, out_is_mul, out_illegal,
           id_jmp, id_jmp_addr
  );

  modport slave (
    input  flush, in_valid, in_inst, in_pc, in_compressed, out_ready,
    output in_ready, out_valid, out_op, out_imm, out_src1, out_src2, out_dest,
           out_funct3, out_funct7, out_pc, out_compressed, out_is_mul, out_illegal,
           id_jmp, id_jmp_addr
  );
endinterface

// File: rtl/xrv_id_pipe.sv
// RV32 decode stage: decodes on the way in, buffers decoded entries in a small
// FIFO, and raises a one-cycle early redirect for accepted JALs.
module xrv_id_pipe #(
  parameter int BUF_DEPTH = 2,
  parameter int HAS_MUL   = 1,
  parameter int HAS_SYS   = 1,
  parameter int EARLY_JAL = 1
) (
  input logic clk,
  input logic rst,
  xrv_id_pipe_if.slave bus
);
  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = $clog2(BUF_DEPTH + 1);

  // op one-hot bit positions
  localparam int OP_LUI = 0, OP_AUIPC = 1, OP_JAL = 2, OP_JALR = 3, OP_BRANCH = 4,
                 OP_LOAD = 5, OP_STORE = 6, OP_IMM = 7, OP_REG = 8, OP_FENCE = 9, OP_SYS = 10;

  typedef struct packed {
    logic [10:0] op;
    logic [31:0] imm;
    logic [4:0]  src1;
    logic [4:0]  src2;
    logic [4:0]  dest;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] pc;
    logic        compressed;
    logic        is_mul;
    logic        illegal;
  } entry_t;

  logic [31:0] inst;
  logic [4:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  entry_t      dec;

  assign inst  = bus.in_inst;
  assign opc   = inst[6:2];
  assign f3    = inst[14:12];
  assign f7    = inst[31:25];
  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'b0};
  assign imm_j = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};

  // Combinational decode of the presented instruction
  always_comb begin
    dec            = '0;
    dec.src1       = inst[19:15];
    dec.src2       = inst[24:20];
    dec.dest       = inst[11:7];
    dec.funct3     = f3;
    dec.funct7     = f7;
    dec.pc         = bus.in_pc;
    dec.compressed = bus.in_compressed;
    if (inst[1:0] != 2'b11) begin
      dec.illegal = 1'b1;
    end else begin
      case (opc)
        5'b01101: begin dec.op[OP_LUI]    = 1'b1; dec.imm = imm_u; end
        5'b00101: begin dec.op[OP_AUIPC]  = 1'b1; dec.imm = imm_u; end
        5'b11011: begin dec.op[OP_JAL]    = 1'b1; dec.imm = imm_j; end
        5'b11001: begin dec.op[OP_JALR]   = 1'b1; dec.imm = imm_i; end
        5'b11000: begin dec.op[OP_BRANCH] = 1'b1; dec.imm = imm_b; end
        5'b00000: begin dec.op[OP_LOAD]   = 1'b1; dec.imm = imm_i; end
        5'b01000: begin dec.op[OP_STORE]  = 1'b1; dec.imm = imm_s; end
        5'b00011: begin dec.op[OP_FENCE]  = 1'b1; dec.imm = imm_i; end
        5'b00100: begin
          dec.op[OP_IMM] = 1'b1;
          dec.imm        = imm_i;
          // shift-immediates only allow the base and arithmetic-shift funct7
          if (f3 == 3'b001 && f7 != 7'h00) dec.illegal = 1'b1;
          if (f3 == 3'b101 && f7 != 7'h00 && f7 != 7'h20) dec.illegal = 1'b1;
        end
        5'b01100: begin
          dec.op[OP_REG] = 1'b1;
          if (f7 == 7'h01 && HAS_MUL != 0) dec.is_mul = 1'b1;
          else if (f7 != 7'h00 && f7 != 7'h20) dec.illegal = 1'b1;
        end
        5'b11100: begin
          dec.op[OP_SYS] = 1'b1;
          dec.imm        = imm_i;
          if (HAS_SYS == 0) dec.illegal = 1'b1;
        end
        default: dec.illegal = 1'b1;
      endcase
    end
    // illegal entries carry no operation class or immediate
    if (dec.illegal) begin
      dec.op     = '0;
      dec.imm    = '0;
      dec.is_mul = 1'b0;
    end
  end

  entry_t          mem [BUF_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   cnt;
  logic            full, accept, pop, jmp_set;
  entry_t          head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full         = (cnt == CW'(BUF_DEPTH));
  assign bus.in_ready = ~rst & (~full | bus.out_ready);
  assign bus.out_valid = (cnt != '0);
  assign accept       = bus.in_valid & bus.in_ready & ~bus.flush;
  assign pop          = bus.out_valid & bus.out_ready;
  assign jmp_set      = (EARLY_JAL != 0) & accept & dec.op[OP_JAL] & ~bus.id_jmp;

  // Entry storage: payload only, occupancy is tracked by the pointers
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= dec;
  end

  // FIFO pointers and occupancy; flush empties everything at the next edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (accept) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)    rd_ptr <= ptr_inc(rd_ptr);
      cnt <= cnt + CW'(accept) - CW'(pop);
    end
  end

  // Early JAL redirect: one pulse, never back-to-back; address holds between pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.id_jmp      <= 1'b0;
      bus.id_jmp_addr <= '0;
    end else begin
      bus.id_jmp <= jmp_set;
      if (jmp_set) bus.id_jmp_addr <= bus.in_pc + imm_j;
    end
  end

  // Payload reads as zero while the FIFO is empty (including out of reset)
  assign head = bus.out_valid ? mem[rd_ptr] : '0;

  assign bus.out_op         = head.op;
  assign bus.out_imm        = head.imm;
  assign bus.out_src1       = head.src1;
  assign bus.out_src2       = head.src2;
  assign bus.out_dest       = head.dest;
  assign bus.out_funct3     = head.funct3;
  assign bus.out_funct7     = head.funct7;
  assign bus.out_pc         = head.pc;
  assign bus.out_compressed = head.compressed;
  assign bus.out_is_mul     = head.is_mul;
  assign bus.out_illegal    = head.illegal;
endmodule

// File: tb/tb_xrv_id_pipe.sv
// Bench for xrv_id_pipe: two instances share stimulus (full-featured and
// HAS_MUL=0/HAS_SYS=0/EARLY_JAL=0), checked against a queue-based model.
module tb_xrv_id_pipe;
  typedef struct packed {
    logic [10:0] op;
    logic [31:0] imm;
    logic [4:0]  s1, s2, rd;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] pc;
    logic        c, mul, ill;
  } ent_t;

  localparam logic [4:0] OPCS [11] = '{5'b01101, 5'b00101, 5'b11011, 5'b11001, 5'b11000,
                                      5'b00000, 5'b01000, 5'b00100, 5'b01100, 5'b00011, 5'b11100};
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  xrv_id_pipe_if ifa ();
  xrv_id_pipe_if ifb ();

  xrv_id_pipe #(.BUF_DEPTH(2), .HAS_MUL(1), .HAS_SYS(1), .EARLY_JAL(1)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  xrv_id_pipe #(.BUF_DEPTH(2), .HAS_MUL(0), .HAS_SYS(0), .EARLY_JAL(0)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  always #5 clk = ~clk;

  ent_t act_a, act_b;
  assign act_a = {ifa.out_op, ifa.out_imm, ifa.out_src1, ifa.out_src2, ifa.out_dest, ifa.out_funct3,
                  ifa.out_funct7, ifa.out_pc, ifa.out_compressed, ifa.out_is_mul, ifa.out_illegal};
  assign act_b = {ifb.out_op, ifb.out_imm, ifb.out_src1, ifb.out_src2, ifb.out_dest, ifb.out_funct3,
                  ifb.out_funct7, ifb.out_pc, ifb.out_compressed, ifb.out_is_mul, ifb.out_illegal};

  // model state
  ent_t        qa[$], qb[$];
  bit          mj;
  logic [31:0] mja;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", n, a, e);
    end
  endtask

  // arithmetic sign extension of an n-bit value
  function automatic logic [31:0] sext(input logic [31:0] v, input int n);
    logic [31:0] m;
    m = 32'(1) << (n - 1);
    return (v ^ m) - m;
  endfunction

  function automatic logic [31:0] jimm(input logic [31:0] i);
    return sext(32'({i[31], i[19:12], i[20], i[30:21], 1'b0}), 21);
  endfunction

  function automatic int op_index(input logic [4:0] o);
    for (int k = 0; k < 11; k++) if (OPCS[k] == o) return k;
    return -1;
  endfunction

  function automatic ent_t mdl(input logic [31:0] i, input logic [31:0] pc, input logic c,
                               input bit hm, input bit hs);
    ent_t e;
    int   k;
    e = '0;
    e.s1 = i[19:15]; e.s2 = i[24:20]; e.rd = i[11:7];
    e.f3 = i[14:12]; e.f7 = i[31:25]; e.pc = pc; e.c = c;
    k = op_index(i[6:2]);
    e.ill = (i[1:0] != 2'b11) || (k < 0);
    if (!e.ill && k == 8 && !(e.f7 == 7'h00 || e.f7 == 7'h20 || (hm && e.f7 == 7'h01))) e.ill = 1'b1;
    if (!e.ill && k == 7 && e.f3 == 3'd1 && e.f7 != 7'h00) e.ill = 1'b1;
    if (!e.ill && k == 7 && e.f3 == 3'd5 && e.f7 != 7'h00 && e.f7 != 7'h20) e.ill = 1'b1;
    if (!e.ill && k == 10 && !hs) e.ill = 1'b1;
    if (!e.ill) begin
      e.op  = 11'(1) << k;
      e.mul = (k == 8) && (e.f7 == 7'h01);
      case (k)
        0, 1:          e.imm = {i[31:12], 12'h000};
        2:             e.imm = jimm(i);
        3, 5, 7, 9, 10: e.imm = sext(32'(i[31:20]), 12);
        4:             e.imm = sext(32'({i[31], i[7], i[30:25], i[11:8], 1'b0}), 13);
        6:             e.imm = sext(32'({i[31:25], i[11:7]}), 12);
        default:       e.imm = 32'h0;
      endcase
    end
    return e;
  endfunction

  task automatic cmp_ent(input string t, input ent_t a, input ent_t e);
    chk({t, "_op"},  64'(a.op),  64'(e.op));
    chk({t, "_imm"}, 64'(a.imm), 64'(e.imm));
    chk({t, "_regs"}, 64'({a.s1, a.s2, a.rd}), 64'({e.s1, e.s2, e.rd}));
    chk({t, "_fn"},  64'({a.f3, a.f7}), 64'({e.f3, e.f7}));
    chk({t, "_pc"},  64'(a.pc),  64'(e.pc));
    chk({t, "_flags"}, 64'({a.c, a.mul, a.ill}), 64'({e.c, e.mul, e.ill}));
  endtask

  // One cycle: drive inputs, check ready, advance the model at the edge,
  // then compare all outputs on the falling edge.
  task automatic step(input bit r, input bit v, input logic [31:0] inst, input logic [31:0] pc,
                      input bit c, input bit ordy, input bit fl);
    bit   erdy, acc, pop, jal, nj;
    ent_t ea, eb;
    rst = r;
    ifa.in_valid = v; ifa.in_inst = inst; ifa.in_pc = pc; ifa.in_compressed = c;
    ifa.out_ready = ordy; ifa.flush = fl;
    ifb.in_valid = v; ifb.in_inst = inst; ifb.in_pc = pc; ifb.in_compressed = c;
    ifb.out_ready = ordy; ifb.flush = fl;
    if (r) begin qa.delete(); qb.delete(); mj = 0; mja = '0; end
    #1;
    erdy = !r && (qa.size() < 2 || ordy);
    chk("in_ready_a", 64'(ifa.in_ready), 64'(erdy));
    chk("in_ready_b", 64'(ifb.in_ready), 64'(erdy));
    acc = v && erdy && !fl;
    pop = (qa.size() > 0) && ordy;
    ea  = mdl(inst, pc, c, 1'b1, 1'b1);
    eb  = mdl(inst, pc, c, 1'b0, 1'b0);
    jal = (inst[6:0] == 7'h6F);
    @(posedge clk);
    if (r) begin
      qa.delete(); qb.delete(); mj = 0; mja = '0;
    end else begin
      nj = acc && jal && !mj;
      if (nj) mja = pc + jimm(inst);
      mj = nj;
      if (fl) begin
        qa.delete(); qb.delete();
      end else begin
        if (pop) begin void'(qa.pop_front()); void'(qb.pop_front()); end
        if (acc) begin qa.push_back(ea); qb.push_back(eb); end
      end
    end
    @(negedge clk);
    chk("out_valid_a", 64'(ifa.out_valid), 64'(qa.size() > 0));
    chk("out_valid_b", 64'(ifb.out_valid), 64'(qb.size() > 0));
    if (qa.size() > 0) cmp_ent("a", act_a, qa[0]);
    if (qb.size() > 0) cmp_ent("b", act_b, qb[0]);
    chk("id_jmp_a", 64'(ifa.id_jmp), 64'(mj));
    if (mj) chk("id_jmp_addr_a", 64'(ifa.id_jmp_addr), 64'(mja));
    chk("id_jmp_b", 64'(ifb.id_jmp), 64'(0));
  endtask

  function automatic logic [31:0] rnd_inst();
    logic [31:0] r;
    int          s;
    r = $urandom;
    s = $urandom_range(0, 13);
    if (s < 11) begin
      r[6:0] = {OPCS[s], 2'b11};
      if (s == 8) begin
        case ($urandom_range(0, 3))
          0: r[31:25] = 7'h00;
          1: r[31:25] = 7'h20;
          2: r[31:25] = 7'h01;
          default: ;
        endcase
      end
      if (s == 7 && $urandom_range(0, 1) == 1) begin
        r[14:12] = ($urandom_range(0, 1) == 1) ? 3'd1 : 3'd5;
        case ($urandom_range(0, 2))
          0: r[31:25] = 7'h00;
          1: r[31:25] = 7'h20;
          default: ;
        endcase
      end
    end else if (s == 11) begin
      r[1:0] = 2'($urandom_range(0, 2));
    end
    return r;
  endfunction

  initial begin
    ifa.in_valid = 0; ifa.in_inst = '0; ifa.in_pc = '0; ifa.in_compressed = 0; ifa.out_ready = 0; ifa.flush = 0;
    ifb.in_valid = 0; ifb.in_inst = '0; ifb.in_pc = '0; ifb.in_compressed = 0; ifb.out_ready = 0; ifb.flush = 0;
    mj = 0; mja = '0;
    @(negedge clk);
    step(1, 0, NOP, 0, 0, 0, 0);
    step(1, 1, NOP, 0, 0, 1, 0);
    // reset state
    chk("rst_out_valid", 64'(ifa.out_valid), 64'(0));
    chk("rst_out_op", 64'(ifa.out_op), 64'(0));
    chk("rst_out_imm", 64'(ifa.out_imm), 64'(0));
    chk("rst_out_pc", 64'(ifa.out_pc), 64'(0));
    chk("rst_id_jmp", 64'(ifa.id_jmp), 64'(0));
    chk("rst_id_jmp_addr", 64'(ifa.id_jmp_addr), 64'(0));
    chk("rst_in_ready", 64'(ifa.in_ready), 64'(0));

    // reset mid-stream with two entries queued
    step(0, 1, NOP, 32'h10, 0, 0, 0);
    step(0, 1, NOP, 32'h14, 0, 0, 0);
    step(1, 1, NOP, 32'h18, 0, 0, 0);
    chk("mid_rst_out_valid", 64'(ifa.out_valid), 64'(0));
    chk("mid_rst_id_jmp", 64'(ifa.id_jmp), 64'(0));
    chk("mid_rst_in_ready", 64'(ifa.in_ready), 64'(0));
    rst = 0;
    #1 chk("post_rst_in_ready", 64'(ifa.in_ready), 64'(1));
    step(0, 1, NOP, 32'h20, 0, 1, 0);
    chk("post_rst_latency", 64'({ifa.out_valid, ifa.out_pc}), 64'({1'b1, 32'h20}));

    // addi x1, x0, -1
    step(0, 1, 32'hFFF0_0093, 32'h40, 0, 1, 0);
    chk("addi_op", 64'(ifa.out_op), 64'(11'h080));
    chk("addi_imm", 64'(ifa.out_imm), 64'(32'hFFFF_FFFF));
    chk("addi_regs", 64'({ifa.out_src1, ifa.out_dest, ifa.out_illegal}), 64'({5'd0, 5'd1, 1'b0}));

    // jal x0, -4 at 0x100
    step(0, 1, 32'hFFDF_F06F, 32'h100, 0, 1, 0);
    chk("jal_pulse", 64'(ifa.id_jmp), 64'(1));
    chk("jal_addr", 64'(ifa.id_jmp_addr), 64'(32'h0000_00FC));
    chk("jal_imm", 64'(ifa.out_imm), 64'(32'hFFFF_FFFC));
    step(0, 0, NOP, 0, 0, 1, 0);
    chk("jal_pulse_end", 64'(ifa.id_jmp), 64'(0));

    // back-to-back JALs: second is queued but does not pulse
    step(0, 1, 32'h0080_006F, 32'h200, 0, 1, 0);
    step(0, 1, 32'h0080_006F, 32'h300, 0, 1, 0);
    chk("jal_b2b_no_pulse", 64'({ifa.id_jmp, ifa.out_pc}), 64'({1'b0, 32'h300}));

    // mul x3, x1, x2
    step(0, 1, 32'h0220_81B3, 32'h50, 0, 1, 0);
    chk("mul_a", 64'({ifa.out_is_mul, ifa.out_src1, ifa.out_src2, ifa.out_dest, ifa.out_illegal}),
        64'({1'b1, 5'd1, 5'd2, 5'd3, 1'b0}));
    chk("mul_b", 64'({ifb.out_illegal, ifb.out_op, ifb.out_is_mul}), 64'({1'b1, 11'h0, 1'b0}));
    step(0, 0, NOP, 0, 0, 1, 0);

    // backpressure: A,B fill, C waits, then drains in order
    step(0, 1, NOP, 32'hA0, 0, 0, 0);
    step(0, 1, NOP, 32'hB0, 0, 0, 0);
    ifa.out_ready = 0;
    #1 chk("full_in_ready", 64'(ifa.in_ready), 64'(0));
    step(0, 1, NOP, 32'hC0, 0, 0, 0);
    chk("order_A", 64'(ifa.out_pc), 64'(32'hA0));
    step(0, 1, NOP, 32'hC0, 0, 1, 0);
    chk("order_B", 64'(ifa.out_pc), 64'(32'hB0));
    step(0, 0, NOP, 0, 0, 1, 0);
    chk("order_C", 64'(ifa.out_pc), 64'(32'hC0));
    step(0, 0, NOP, 0, 0, 1, 0);
    chk("drained", 64'(ifa.out_valid), 64'(0));

    // flush with two queued and a JAL presented
    step(0, 1, NOP, 32'hD0, 0, 0, 0);
    step(0, 1, NOP, 32'hD4, 0, 0, 0);
    step(0, 1, 32'hFFDF_F06F, 32'h100, 0, 0, 1);
    chk("flush_empty", 64'({ifa.out_valid, ifa.id_jmp}), 64'(0));
    step(0, 0, NOP, 0, 0, 1, 0);
    chk("flush_no_jmp", 64'({ifa.out_valid, ifa.id_jmp}), 64'(0));

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] ins;
      ins = ($urandom_range(0, 7) == 0) ? {$urandom} & 32'hFFFF_FF80 | 32'h6F : rnd_inst();
      step($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 7, ins, $urandom & 32'hFFFF_FFFE,
           1'($urandom_range(0, 1)), $urandom_range(0, 9) < 6, $urandom_range(0, 49) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
